// File: rtl/fir_peak_detector_if.sv
// rtl/fir_peak_detector_if.sv - measurement control, sample stream and peak result bundle
interface fir_peak_detector_if #(
  parameter int DATA_WIDTH = 40,
  parameter int CNT_WIDTH  = 16,
  parameter int OUT_WIDTH  = 16
);
  logic                         start;
  logic [CNT_WIDTH-1:0]         settle_len;
  logic [CNT_WIDTH-1:0]         window_len;
  logic signed [DATA_WIDTH-1:0] din;
  logic                         din_valid;
  logic                         busy;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] peak;
  logic signed [OUT_WIDTH-1:0]  peak_q;
  logic                         sat;

  modport master (
    output start, settle_len, window_len, din, din_valid,
    input  busy, done, peak, peak_q, sat
  );

  modport slave (
    input  start, settle_len, window_len, din, din_valid,
    output busy, done, peak, peak_q, sat
  );
endinterface

// File: rtl/fir_peak_detector.sv
// rtl/fir_peak_detector.sv - settle/window peak capture of filter output with Q2.14 requantization
// Optional FIR_PEAK_ABS_EN: track the peak of |din| instead of signed din.
module fir_peak_detector #(
  parameter int DATA_WIDTH = 40,
  parameter int CNT_WIDTH  = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 14
) (
  input  logic              clk,
  input  logic              rst,
  fir_peak_detector_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_REPORT  = 2'd3;

  logic [1:0]                   state;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [CNT_WIDTH-1:0]         settle_q;
  logic [CNT_WIDTH-1:0]         window_q;
  logic signed [DATA_WIDTH-1:0] run_max;
  logic signed [DATA_WIDTH-1:0] peak_r;
  logic signed [OUT_WIDTH-1:0]  peak_q_r;
  logic                         sat_r;

  logic signed [DATA_WIDTH-1:0] sample;
  logic signed [DATA_WIDTH-1:0] next_max;
  logic signed [DATA_WIDTH-1:0] shifted;
  logic                         sat_hi;
  logic                         sat_lo;
  logic signed [OUT_WIDTH-1:0]  q_val;

`ifdef FIR_PEAK_ABS_EN
  logic signed [DATA_WIDTH:0] din_ext;
  logic signed [DATA_WIDTH:0] din_abs;

  // One extra bit keeps |min| exact; only that single value then needs clamping.
  always_comb begin
    din_ext = {bus.din[DATA_WIDTH-1], bus.din};
    din_abs = din_ext[DATA_WIDTH] ? -din_ext : din_ext;
    sample  = din_abs[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                    : din_abs[DATA_WIDTH-1:0];
  end
`else
  assign sample = bus.din;
`endif

  always_comb begin
    next_max = ((cnt == '0) || (sample > run_max)) ? sample : run_max;
    shifted  = next_max >>> FRAC_SHIFT;
    sat_hi   = !shifted[DATA_WIDTH-1] &&  (|shifted[DATA_WIDTH-2:OUT_WIDTH-1]);
    sat_lo   =  shifted[DATA_WIDTH-1] && !(&shifted[DATA_WIDTH-2:OUT_WIDTH-1]);
    if (sat_hi)
      q_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sat_lo)
      q_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      q_val = shifted[OUT_WIDTH-1:0];
  end

  // Result registers load on the last window edge so they are valid during REPORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      settle_q <= '0;
      window_q <= '0;
      run_max  <= '0;
      peak_r   <= '0;
      peak_q_r <= '0;
      sat_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            settle_q <= bus.settle_len;
            window_q <= (bus.window_len == '0) ? CNT_WIDTH'(1) : bus.window_len;
            cnt      <= '0;
            state    <= (bus.settle_len == '0) ? S_MEASURE : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.din_valid) begin
            if (cnt == settle_q - CNT_WIDTH'(1)) begin
              cnt   <= '0;
              state <= S_MEASURE;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        S_MEASURE: begin
          if (bus.din_valid) begin
            run_max <= next_max;
            if (cnt == window_q - CNT_WIDTH'(1)) begin
              cnt      <= '0;
              peak_r   <= next_max;
              peak_q_r <= q_val;
              sat_r    <= sat_hi || sat_lo;
              state    <= S_REPORT;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_SETTLE) || (state == S_MEASURE);
  assign bus.done   = (state == S_REPORT);
  assign bus.peak   = peak_r;
  assign bus.peak_q = peak_q_r;
  assign bus.sat    = sat_r;
endmodule

// File: tb/tb_fir_peak_detector.sv
// tb/tb_fir_peak_detector.sv - table-driven scoreboard bench for fir_peak_detector
module tb_fir_peak_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_peak_detector_if #(.DATA_WIDTH(40), .CNT_WIDTH(16), .OUT_WIDTH(16)) bus ();

  fir_peak_detector #(.DATA_WIDTH(40), .CNT_WIDTH(16), .OUT_WIDTH(16), .FRAC_SHIFT(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0]        settle;
    logic [15:0]        window;
    int                 n;
    logic signed [39:0] s [8];
    bit                 toggle;
    logic signed [39:0] e_peak;
    logic signed [15:0] e_q;
    logic               e_sat;
  } vec_t;

  typedef struct packed {
    logic signed [39:0] peak;
    logic signed [15:0] q;
    logic               sat;
  } exp_t;

  vec_t vecs [9];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("peak",   64'(bus.peak),   64'(e.peak));
        chk("peak_q", 64'(bus.peak_q), 64'(e.q));
        chk("sat",    64'(bus.sat),    64'(e.sat));
      end
    end
  end

  task automatic set_vec(input int k, input int settle, input int window, input int n,
                         input bit toggle, input logic signed [39:0] a0, input logic signed [39:0] a1,
                         input logic signed [39:0] a2, input logic signed [39:0] a3,
                         input logic signed [39:0] a4, input logic signed [39:0] a5,
                         input logic signed [39:0] a6, input logic signed [39:0] a7,
                         input logic signed [39:0] ep, input logic signed [15:0] eq, input logic es);
    vecs[k].settle = 16'(settle);
    vecs[k].window = 16'(window);
    vecs[k].n      = n;
    vecs[k].toggle = toggle;
    vecs[k].s[0] = a0; vecs[k].s[1] = a1; vecs[k].s[2] = a2; vecs[k].s[3] = a3;
    vecs[k].s[4] = a4; vecs[k].s[5] = a5; vecs[k].s[6] = a6; vecs[k].s[7] = a7;
    vecs[k].e_peak = ep;
    vecs[k].e_q    = eq;
    vecs[k].e_sat  = es;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    exp_q.push_back({v.e_peak, v.e_q, v.e_sat});
    bus.start      = 1'b1;
    bus.settle_len = v.settle;
    bus.window_len = v.window;
    bus.din_valid  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_rise", 64'(bus.busy), 64'd1);
    for (int i = 0; i < v.n; i++) begin
      bus.din       = v.s[i];
      bus.din_valid = 1'b1;
      @(posedge clk); #1;
      if (v.toggle && i < v.n - 1) begin
        // Idle cycle carries a huge bogus sample and a stray start; both must be ignored.
        bus.din_valid = 1'b0;
        bus.din       = 40'sh4000000000;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    bus.din_valid = 1'b0;
    chk("done_latency", 64'(bus.done), 64'd1);
    chk("busy_fall",    64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("done_pulse",   64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.settle_len = '0; bus.window_len = '0;
    bus.din = '0; bus.din_valid = 1'b0;

    set_vec(0, 3, 5, 8, 0, 10, 20, 30, 5, -7, 40, 2, 39, 40, 16'sd0, 1'b0);
    set_vec(1, 0, 1, 1, 0, 49152, 0, 0, 0, 0, 0, 0, 0, 49152, 16'sd3, 1'b0);
    set_vec(2, 0, 2, 2, 0, 40'sh4000000000, 0, 0, 0, 0, 0, 0, 0, 40'sh4000000000, 16'sd32767, 1'b1);
    set_vec(3, 2, 2, 4, 1, 1, 2, 8, 4, 0, 0, 0, 0, 8, 16'sd0, 1'b0);
    set_vec(5, 1, 0, 2, 0, 1000, 7, 0, 0, 0, 0, 0, 0, 7, 16'sd0, 1'b0);
`ifdef FIR_PEAK_ABS_EN
    set_vec(4, 0, 3, 3, 0, -100, -50, -75, 0, 0, 0, 0, 0, 100, 16'sd0, 1'b0);
    set_vec(6, 0, 1, 1, 0, -40'sh4000000000, 0, 0, 0, 0, 0, 0, 0, 40'sh4000000000, 16'sd32767, 1'b1);
    set_vec(7, 0, 1, 1, 0, 40'sh8000000000, 0, 0, 0, 0, 0, 0, 0, 40'sh7fffffffff, 16'sd32767, 1'b1);
    set_vec(8, 0, 3, 3, 0, -5, -5, -9, 0, 0, 0, 0, 0, 9, 16'sd0, 1'b0);
`else
    set_vec(4, 0, 3, 3, 0, -100, -50, -75, 0, 0, 0, 0, 0, -50, -16'sd1, 1'b0);
    set_vec(6, 0, 1, 1, 0, -40'sh4000000000, 0, 0, 0, 0, 0, 0, 0, -40'sh4000000000, -16'sd32768, 1'b1);
    set_vec(7, 0, 1, 1, 0, 40'sh8000000000, 0, 0, 0, 0, 0, 0, 0, 40'sh8000000000, -16'sd32768, 1'b1);
    set_vec(8, 0, 3, 3, 0, -5, -5, -9, 0, 0, 0, 0, 0, -5, -16'sd1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_peak",   64'(bus.peak),   64'd0);
    chk("rst_peak_q", 64'(bus.peak_q), 64'd0);
    chk("rst_sat",    64'(bus.sat),    64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) run_vec(k);

    // Reset in the middle of MEASURE: aborts with no done and clears outputs.
    bus.start = 1'b1; bus.settle_len = 16'd0; bus.window_len = 16'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.din = 40'(1000 + i); bus.din_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy",   64'(bus.busy),   64'd0);
    chk("abort_done",   64'(bus.done),   64'd0);
    chk("abort_peak",   64'(bus.peak),   64'd0);
    chk("abort_peak_q", 64'(bus.peak_q), 64'd0);
    chk("abort_sat",    64'(bus.sat),    64'd0);
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(0);

    // start held high through REPORT: one idle cycle, then a fresh measurement.
    exp_q.push_back({40'sd11, 16'sd0, 1'b0});
    exp_q.push_back({40'sd12, 16'sd0, 1'b0});
    bus.start = 1'b1; bus.settle_len = 16'd0; bus.window_len = 16'd1;
    @(posedge clk); #1;
    bus.din = 40'sd11; bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    chk("b2b_done1", 64'(bus.done), 64'd1);
    @(posedge clk); #1;
    chk("b2b_gap_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("b2b_busy2", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    bus.din = 40'sd12; bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    chk("b2b_done2", 64'(bus.done), 64'd1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_peak_detector.md
# fir_peak_detector

Downstream measurement stage for the pipelined `fir_filter`. It consumes the filter's 40-bit signed output stream and waits a programmable number of settling samples while the taps fill. It then captures the maximum output over a programmable window and reports the peak both full-width and requantized to Q2.14 16-bit. This moves the max-tracking loop used in frequency-sweep characterisation into synthesizable hardware.

## Interface
- `DATA_WIDTH`, 40, width of filter output `din`.
- `CNT_WIDTH`, 16, width of settle/window counters and length inputs.
- `OUT_WIDTH`, 16, width of requantized peak `peak_q`.
- `FRAC_SHIFT`, 14, arithmetic right shift applied to form `peak_q` (filter output scale 2^14).

One clock; reset is asynchronous and active-high.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a measurement; sampled only in IDLE.
- `settle_len` in CNT_WIDTH: valid samples to discard before measuring; latched on accepted `start`.
- `window_len` in CNT_WIDTH: valid samples to measure; latched on accepted `start`.
- `din` in DATA_WIDTH, signed: filter output sample.
- `din_valid` in 1: `din` carries a sample this cycle.
- `busy` out 1: high in SETTLE and MEASURE.
- `done` out 1: one-cycle pulse when a measurement completes.
- `peak` out DATA_WIDTH, signed: registered maximum of the last completed window.
- `peak_q` out OUT_WIDTH, signed: `peak >>> FRAC_SHIFT`, saturated to OUT_WIDTH.
- `sat` out 1: high when `peak_q` was saturated.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE: on `start`=1, latch lengths and clear counter.
  - If `settle_len`=0, go to MEASURE; otherwise go to SETTLE.
  - `window_len`=0 is treated as 1.
- SETTLE: count accepted samples (`din_valid`=1) and discard them. When the count reaches `settle_len`, clear the counter and go to MEASURE.
- MEASURE: the first accepted sample loads the running max unconditionally. Each later sample replaces the running max when it is strictly greater, using a signed compare. After `window_len` accepted samples, go to REPORT.
- REPORT: present for one cycle.
  - Transfer running max to `peak`; compute `peak_q` and `sat`; assert `done`.
  - Return to IDLE.
- Requantization: arithmetic shift right by FRAC_SHIFT.
  - If the result exceeds 2^(OUT_WIDTH-1)-1, clamp to that value.
  - If the result is below -2^(OUT_WIDTH-1), clamp to that value.
  - Set `sat`=1 whenever either clamp applies.
- `start` outside IDLE is ignored; it is not queued.
- Cycles with `din_valid`=0 do not advance counters in any state.
- `peak`, `peak_q` and `sat` hold their values until the next REPORT.

## Timing
- Reset values:
  - State IDLE, all counters 0, running max 0.
  - `busy`=0, `done`=0, `peak`=0, `peak_q`=0, `sat`=0.
- Reset mid-measurement aborts immediately. No `done` is issued; outputs return to reset values.
- `busy` rises the cycle after an accepted `start` and falls in the REPORT cycle.
- Latency: `done` asserts exactly one cycle after the edge that accepts the last window sample. `peak`, `peak_q` and `sat` are valid in that same cycle.
- A sample accepted on the same edge as the SETTLE→MEASURE transition belongs to SETTLE. Measurement begins with the next valid sample.
- `start` held high across REPORT→IDLE starts a new measurement on the first IDLE cycle; back-to-back measurements therefore have a one-cycle gap.
- Counters compare with the length value and never wrap. Maximum lengths are 2^CNT_WIDTH-1.

## Configuration
- Macro: `FIR_PEAK_ABS_EN`.
- Defined: MEASURE tracks the maximum of |din| instead of signed `din`.
  - The absolute value is computed at DATA_WIDTH+1 bits, so |−2^(DATA_WIDTH−1)| is exact.
  - `peak` carries the magnitude, saturated to 2^(DATA_WIDTH−1)−1.
- Undefined: signed maximum only, with no absolute-value logic synthesized.

## Test plan
- Continuous `din_valid` with settle 3, window 5, din = 10,20,30 (discarded), then 5,−7,40,2,39 → `done` one cycle after the fifth window sample; `peak`=40; `peak_q`=0; `sat`=0.
- Settle 0, window 1, din = 3·2^14 → `peak`=49152, `peak_q`=3, `done` after one sample.
- Window 2, din = 2^40/4 then 0 → `peak_q`=32767, `sat`=1.
- `din_valid` toggling 1,0,1,0, settle 2, window 2 → `done` only after four valid samples; invalid cycles are ignored. Also pulse `start` during `busy` → no effect.
- All-negative window −100,−50,−75 → `peak`=−50. With `FIR_PEAK_ABS_EN` defined, the same window gives `peak`=100.
- Assert `rst` mid-MEASURE → `busy`=0 and `peak`=0 immediately with no `done`. A new `start` after release measures correctly.
